mdu_ctrl: RTL and testbench

// - Sequences the multi-cycle multiply/divide unit in the EX stage and drives the 2-bit select of the EX result 4:1 mux (ALU / HI / LO / PC+8).
// - Owns the HI/LO registers, counts operation latency and raises stall_req to the hazard logic while a result is not yet available.
// - One requester, the decoded EX-stage instruction; one shared resource, the HI/LO result path.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_ctrl_if.sv | 23 ++
 rtl/mdu_arith.sv | 56 +++++
 rtl/mdu_ctrl.sv | 112 +++++++++++
 tb/tb_mdu_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, result-mux
// selects and the sequencer state enum.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_HI  = 2'd1,
    WB_LO  = 2'd2,
    WB_PC8 = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  function automatic logic is_div_op(logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> MDU signal bundle: request side (master) and MDU side (slave).
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [1:0]  mf_req;
  logic        busy;
  logic        stall_req;
  logic [1:0]  wb_sel;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, mf_req,
    input  busy, stall_req, wb_sel, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, mf_req,
    output busy, stall_req, wb_sel, hi, lo
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: latched operands + op -> next {hi, lo}.
// Accumulating multiplies (ops 6/7) exist only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_cur,
  input  logic [31:0] lo_cur,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;
  logic               div_zero;
  logic               div_ovf;

  always_comb begin
    prod_s   = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    prod_u   = {32'd0, a} * {32'd0, b};
    q_s      = $signed(a) / $signed(b);
    r_s      = $signed(a) % $signed(b);
    q_u      = a / b;
    r_u      = a % b;
    div_zero = (b == 32'd0);
    // Most-negative / -1 overflows 32 bits; pin the result explicitly
    div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    {hi_n, lo_n} = {hi_cur, lo_cur};

    case (op)
      OP_MULT:  {hi_n, lo_n} = prod_s;
      OP_MULTU: {hi_n, lo_n} = prod_u;
      OP_DIV: begin
        if (div_zero)     {hi_n, lo_n} = {a, 32'hFFFF_FFFF};
        else if (div_ovf) {hi_n, lo_n} = {32'd0, 32'h8000_0000};
        else              {hi_n, lo_n} = {r_s, q_s};
      end
      OP_DIVU: begin
        if (div_zero) {hi_n, lo_n} = {a, 32'hFFFF_FFFF};
        else          {hi_n, lo_n} = {r_u, q_u};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {hi_n, lo_n} = {hi_cur, lo_cur} + prod_s;
      OP_MADDU: {hi_n, lo_n} = {hi_cur, lo_cur} + prod_u;
`endif
      default:  {hi_n, lo_n} = {hi_cur, lo_cur};
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage MDU sequencer: FSM, latency counter, HI/LO, stall and result select.
// MDU_MADD_EN enables acceptance of MADD/MADDU (ops 6/7); otherwise they are NOPs.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  mdu_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       op_reg, op_next;
  logic [31:0]      a_reg, a_next;
  logic [31:0]      b_reg, b_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic             busy_reg;
  logic [31:0]      arith_hi, arith_lo;
  logic             mul_op;
  logic             stall;

  mdu_arith u_arith (
    .op     (op_reg),
    .a      (a_reg),
    .b      (b_reg),
    .hi_cur (hi_reg),
    .lo_cur (lo_reg),
    .hi_n   (arith_hi),
    .lo_n   (arith_lo)
  );

`ifdef MDU_MADD_EN
  assign mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                  (bus.op == OP_MADD) || (bus.op == OP_MADDU);
`else
  assign mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      busy_reg  <= (state_next != ST_IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          if (mul_op || is_div_op(bus.op)) begin
            state_next = mul_op ? ST_MUL : ST_DIV;
            cnt_next   = mul_op ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
            op_next    = bus.op;
            a_next     = bus.rs_val;
            b_next     = bus.rt_val;
          end else if (bus.op == OP_MTHI) begin
            hi_next = bus.rs_val;
          end else if (bus.op == OP_MTLO) begin
            lo_next = bus.rs_val;
          end
        end
      end
      default: begin
        cnt_next = cnt_reg - CNT_W'(1);
        // Final cycle: retire the op, result lands on this edge
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_IDLE;
          hi_next    = arith_hi;
          lo_next    = arith_lo;
        end
      end
    endcase
  end

  assign stall         = busy_reg && (bus.start || (bus.mf_req == WB_HI) || (bus.mf_req == WB_LO));
  assign bus.busy      = busy_reg;
  assign bus.stall_req = stall;
  assign bus.wb_sel    = (!reset || stall) ? WB_ALU : bus.mf_req;
  assign bus.hi        = hi_reg;
  assign bus.lo        = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized self-checking bench for mdu_ctrl against an arithmetic reference model.
// Build with MDU_MADD_EN defined to exercise the accumulating multiplies.
module tb_mdu_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected {hi,lo} after an op completes, from the arithmetic definitions
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; return p; end
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      3'd4: return {a, hl[31:0]};
      3'd5: return {hl[63:32], a};
`ifdef MDU_MADD_EN
      3'd6: begin p = sa * sb; return hl + p; end
      3'd7: return hl + ua * ub;
`endif
      default: return hl;
    endcase
  endfunction

  function automatic int op_latency(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return MUL_LAT;
      3'd2, 3'd3: return DIV_LAT;
`ifdef MDU_MADD_EN
      3'd6, 3'd7: return MUL_LAT;
`endif
      default:    return 0;
    endcase
  endfunction

  // Issue one op from an idle MDU and follow it to completion
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [63:0] exp;
    lat = op_latency(op);
    exp = model(op, a, b, {m_hi, m_lo});
    bus.start = 1'b1; bus.op = op; bus.rs_val = a; bus.rt_val = b; bus.mf_req = 2'd0;
    #1;
    check("idle_no_stall", {63'd0, bus.stall_req}, 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check("busy_during_op", {63'd0, bus.busy}, 64'd1);
      if (k == lat) check("hilo_before_done", {bus.hi, bus.lo}, {m_hi, m_lo});
      if (k < lat) begin @(posedge clk); #1; end
    end
    if (lat > 0) @(posedge clk);
    {m_hi, m_lo} = exp;
    @(negedge clk);
    check("busy_after_op", {63'd0, bus.busy}, 64'd0);
    check("hilo_result", {bus.hi, bus.lo}, exp);
    $display("[TB] op=%0d a=%h b=%h -> hi=%h lo=%h", op, a, b, bus.hi, bus.lo);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [63:0] first;
    n_tests = 0;
    n_fail  = 0;
    m_hi    = 32'd0;
    m_lo    = 32'd0;
    reset   = 1'b0;
    bus.start = 1'b0; bus.op = 3'd0; bus.rs_val = 32'd0; bus.rt_val = 32'd0;
    bus.mf_req = 2'd1;

    // Reset held: everything quiet even with an MFHI request present
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_stall", {63'd0, bus.stall_req}, 64'd0);
    check("rst_wb_sel", {62'd0, bus.wb_sel}, 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b1;
    bus.mf_req = 2'd0;
    @(posedge clk); #1;

    // Directed cases
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd3, 32'd7, 32'd0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

    // MFLO two cycles into a MULT: stalled with ALU select until the result lands
    first = model(3'd0, 32'd1000, 32'd3, {m_hi, m_lo});
    bus.start = 1'b1; bus.op = 3'd0; bus.rs_val = 32'd1000; bus.rt_val = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= MUL_LAT; k++) begin
      if (k == 2) bus.mf_req = 2'd2;
      @(negedge clk);
      if (k >= 2) begin
        check("mflo_stall", {63'd0, bus.stall_req}, 64'd1);
        check("mflo_wb_sel_stalled", {62'd0, bus.wb_sel}, 64'd0);
      end
      @(posedge clk); #1;
    end
    {m_hi, m_lo} = first;
    @(negedge clk);
    check("mflo_released", {63'd0, bus.stall_req}, 64'd0);
    check("mflo_wb_sel", {62'd0, bus.wb_sel}, 64'd2);
    check("mflo_lo", {32'd0, bus.lo}, {32'd0, m_lo});
    $display("[TB] mflo during mult -> lo=%h wb_sel=%0d", bus.lo, bus.wb_sel);
    bus.mf_req = 2'd0;
    @(posedge clk); #1;

    // Second MULT held while busy: accepted on the first idle cycle
    first = model(3'd0, 32'd6, 32'd7, {m_hi, m_lo});
    bus.start = 1'b1; bus.op = 3'd0; bus.rs_val = 32'd6; bus.rt_val = 32'd7;
    @(posedge clk); #1;
    bus.rs_val = 32'hFFFF_FFFD; bus.rt_val = 32'd9;
    for (int k = 1; k <= MUL_LAT; k++) begin
      @(negedge clk);
      check("second_start_stall", {63'd0, bus.stall_req}, 64'd1);
      @(posedge clk); #1;
    end
    {m_hi, m_lo} = first;
    check("first_result", {bus.hi, bus.lo}, first);
    check("idle_accept_no_stall", {63'd0, bus.stall_req}, 64'd0);
    first = model(3'd0, 32'hFFFF_FFFD, 32'd9, {m_hi, m_lo});
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (MUL_LAT - 1) @(posedge clk);
    @(negedge clk);
    check("second_not_yet", {bus.hi, bus.lo}, {m_hi, m_lo});
    @(posedge clk); #1;
    {m_hi, m_lo} = first;
    check("second_result", {bus.hi, bus.lo}, first);
    $display("[TB] back-to-back mult -> hi=%h lo=%h", bus.hi, bus.lo);

    // MTHI with a same-cycle MFHI: old value read, write lands at the edge
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.rs_val = 32'h0000_1234; bus.mf_req = 2'd1;
    #1;
    check("mthi_no_stall", {63'd0, bus.stall_req}, 64'd0);
    check("mthi_wb_sel", {62'd0, bus.wb_sel}, 64'd1);
    check("mthi_old_hi", {32'd0, bus.hi}, {32'd0, m_hi});
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mf_req = 2'd0;
    m_hi = 32'h0000_1234;
    check("mthi_new_hi", {32'd0, bus.hi}, {32'd0, m_hi});
    $display("[TB] mthi -> hi=%h", bus.hi);
    @(negedge clk);

    // Reset pulsed mid-DIV aborts the op and clears HI/LO at once
    bus.start = 1'b1; bus.op = 3'd2; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset mid-div -> hi=%h lo=%h", bus.hi, bus.lo);
    @(posedge clk); #1;

    // Accumulating multiply (or NOP when the feature is absent)
    run_op(3'd5, 32'd1, 32'd0);
    run_op(3'd7, 32'd3, 32'd4);
    run_op(3'd6, 32'hFFFF_FFFF, 32'd5);

    // Random ops with occasional divide corner cases
    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2: begin r_a = 32'($urandom_range(0, 50)); r_b = 32'($urandom_range(0, 9)) - 32'd4; end
        default: ;
      endcase
      run_op(r_op, r_a, r_b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
